// File: rtl/seven_sensor_frame_tx.sv
// Snapshots seven sensors on load, sends start|X1..X7|quorum|even parity|stop, each bit held BIT_CYCLES clocks.
// busy rises the cycle after load, 11*BIT_CYCLES busy cycles, then a one-cycle done; load while busy is dropped.
module seven_sensor_frame_tx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       X1,
    input  logic       X2,
    input  logic       X3,
    input  logic       X4,
    input  logic       X5,
    input  logic       X6,
    input  logic       X7,
    input  logic       load,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] count,
    output logic       quorum
);

    typedef enum logic [2:0] {IDLE, START, DATA, QUOR, PAR, STOP} state_t;

    localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

    state_t     state_q;
    logic [7:0] cyc_q;
    logic [2:0] bit_q;
    logic [6:0] data_q;
    logic [2:0] count_q;
    logic       quorum_q;
    logic       parity_q;
    logic       tx_q;
    logic       busy_q;
    logic       done_q;

    logic [6:0] sensors_d;
    logic [2:0] count_d;
    logic       quorum_d;
    logic       parity_d;
    logic       wrap;

    always_comb begin
        sensors_d = {X7, X6, X5, X4, X3, X2, X1};
        count_d   = {2'b00, X1} + {2'b00, X2} + {2'b00, X3} + {2'b00, X4}
                  + {2'b00, X5} + {2'b00, X6} + {2'b00, X7};
        // count of 6 or 7 is exactly the codes with both upper bits set
        quorum_d  = count_d[2] & count_d[1];
        parity_d  = (^sensors_d) ^ quorum_d;
        wrap      = (cyc_q == LAST);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            cyc_q    <= 8'd0;
            bit_q    <= 3'd0;
            data_q   <= 7'd0;
            count_q  <= 3'd0;
            quorum_q <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                cyc_q <= wrap ? 8'd0 : cyc_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (load) begin
                        data_q   <= sensors_d;
                        count_q  <= count_d;
                        quorum_q <= quorum_d;
                        parity_q <= parity_d;
                        cyc_q    <= 8'd0;
                        bit_q    <= 3'd0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (wrap) begin
                        tx_q    <= data_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        if (bit_q == 3'd6) begin
                            tx_q    <= quorum_q;
                            state_q <= QUOR;
                        end else begin
                            // data_q shifts right so the next bit is always at [1]
                            data_q <= {1'b0, data_q[6:1]};
                            tx_q   <= data_q[1];
                            bit_q  <= bit_q + 3'd1;
                        end
                    end
                end
                QUOR: begin
                    if (wrap) begin
                        tx_q    <= parity_q;
                        state_q <= PAR;
                    end
                end
                PAR: begin
                    if (wrap) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign count  = count_q;
    assign quorum = quorum_q;

endmodule

// File: tb/tb_seven_sensor_frame_tx.sv
// Directed bench: a BIT_CYCLES=4 and a BIT_CYCLES=1 instance share clock, reset and sensors.
module tb_seven_sensor_frame_tx;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [6:0] xv;
    logic       load4;
    logic       load1;

    logic       tx4, busy4, done4, quorum4;
    logic [2:0] count4;
    logic       tx1, busy1, done1, quorum1;
    logic [2:0] count1;

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    seven_sensor_frame_tx #(.BIT_CYCLES(4)) dut4 (
        .Clock(Clock), .Resetn(Resetn),
        .X1(xv[0]), .X2(xv[1]), .X3(xv[2]), .X4(xv[3]), .X5(xv[4]), .X6(xv[5]), .X7(xv[6]),
        .load(load4), .tx(tx4), .busy(busy4), .done(done4), .count(count4), .quorum(quorum4)
    );

    seven_sensor_frame_tx #(.BIT_CYCLES(1)) dut1 (
        .Clock(Clock), .Resetn(Resetn),
        .X1(xv[0]), .X2(xv[1]), .X3(xv[2]), .X4(xv[3]), .X5(xv[4]), .X6(xv[5]), .X7(xv[6]),
        .load(load1), .tx(tx1), .busy(busy1), .done(done1), .count(count1), .quorum(quorum1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Caller has driven xv/load at a negedge; the next posedge is acceptance edge N.
    task automatic check_frame(input int inst, input logic [6:0] x, input logic [2:0] ec,
                               input logic eq, input logic ep, input int chg_k,
                               input logic [6:0] chg_x, input bit drop_load);
        logic [10:0] bits;
        int bc;
        bc = (inst == 1) ? 1 : 4;
        bits = {1'b1, ep, eq, x, 1'b0};
        @(posedge Clock);
        @(negedge Clock);
        if (drop_load) begin
            load4 = 1'b0;
            load1 = 1'b0;
        end
        check($sformatf("i%0d count", inst), (inst == 1) ? count1 : count4, ec);
        check($sformatf("i%0d quorum", inst), (inst == 1) ? quorum1 : quorum4, eq);
        for (int k = 0; k < 11 * bc; k++) begin
            if (k > 0) @(negedge Clock);
            if (k == chg_k) xv = chg_x;
            check($sformatf("i%0d tx bit%0d cyc%0d", inst, k / bc, k), (inst == 1) ? tx1 : tx4, bits[k / bc]);
            check($sformatf("i%0d busy cyc%0d", inst, k), (inst == 1) ? busy1 : busy4, 1);
            check($sformatf("i%0d done early cyc%0d", inst, k), (inst == 1) ? done1 : done4, 0);
        end
        @(negedge Clock);
        check($sformatf("i%0d done pulse", inst), (inst == 1) ? done1 : done4, 1);
        check($sformatf("i%0d busy end", inst), (inst == 1) ? busy1 : busy4, 0);
        check($sformatf("i%0d tx idle", inst), (inst == 1) ? tx1 : tx4, 1);
    endtask

    initial begin
        Resetn = 1'b0;
        load4  = 1'b1;
        load1  = 1'b1;
        xv     = 7'b1111111;

        // Reset held two cycles with load asserted
        repeat (2) begin
            @(negedge Clock);
            check("rst tx4", tx4, 1);
            check("rst busy4", busy4, 0);
            check("rst done4", done4, 0);
            check("rst count4", count4, 0);
            check("rst quorum4", quorum4, 0);
            check("rst tx1", tx1, 1);
            check("rst busy1", busy1, 0);
        end
        load4  = 1'b0;
        load1  = 1'b0;
        Resetn = 1'b1;
        @(negedge Clock);
        check("post rst busy4", busy4, 0);
        check("post rst tx4", tx4, 1);
        check("post rst busy1", busy1, 0);

        // X1 and X3 set: count 2, no quorum, parity 0
        xv = 7'b0000101; load4 = 1'b1;
        check_frame(4, 7'b0000101, 3'd2, 1'b0, 1'b0, -1, 7'b0, 1'b1);

        // X1..X6 set: count 6, quorum, parity 1
        xv = 7'b0111111; load4 = 1'b1;
        check_frame(4, 7'b0111111, 3'd6, 1'b1, 1'b1, -1, 7'b0, 1'b1);

        // all seven: count 7, quorum, parity 0
        xv = 7'b1111111; load4 = 1'b1;
        check_frame(4, 7'b1111111, 3'd7, 1'b1, 1'b0, -1, 7'b0, 1'b1);

        // five set: no quorum, parity 1
        xv = 7'b0011111; load4 = 1'b1;
        check_frame(4, 7'b0011111, 3'd5, 1'b0, 1'b1, -1, 7'b0, 1'b1);

        // load held high, sensors change mid-frame; second frame takes done-cycle sensors
        xv = 7'b0000101; load4 = 1'b1;
        check_frame(4, 7'b0000101, 3'd2, 1'b0, 1'b0, 20, 7'b1111111, 1'b0);
        check_frame(4, 7'b1111111, 3'd7, 1'b1, 1'b0, 10, 7'b0000000, 1'b1);
        @(negedge Clock);
        check("no third frame busy4", busy4, 0);
        check("count holds", count4, 7);
        check("quorum holds", quorum4, 1);

        // Reset during D3 aborts the frame
        xv = 7'b1010101; load4 = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        load4 = 1'b0;
        repeat (17) @(negedge Clock);
        check("pre-abort busy4", busy4, 1);
        Resetn = 1'b0;
        @(negedge Clock);
        check("abort tx4", tx4, 1);
        check("abort busy4", busy4, 0);
        check("abort done4", done4, 0);
        check("abort count4", count4, 0);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check($sformatf("abort quiet done4 %0d", i), done4, 0);
            check($sformatf("abort quiet busy4 %0d", i), busy4, 0);
            check($sformatf("abort quiet tx4 %0d", i), tx4, 1);
        end
        xv = 7'b0011111; load4 = 1'b1;
        check_frame(4, 7'b0011111, 3'd5, 1'b0, 1'b1, -1, 7'b0, 1'b1);

        // BIT_CYCLES=1, all zeros
        xv = 7'b0000000; load1 = 1'b1;
        check_frame(1, 7'b0000000, 3'd0, 1'b0, 1'b0, -1, 7'b0, 1'b1);
        @(negedge Clock);
        check("i1 done single", done1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
